switch_out_queue: RTL and testbench

//  Per-port egress queue of the switch, directly upstream of the output port pins (port_out/port_ready/port_read).

---
 rtl/switch_out_queue.sv | 155 +++++++++++++++
 tb/tb_switch_out_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_out_queue.sv
// ============================================================================
//  Module      : switch_out_queue
//  Description : Per-port store-and-forward egress queue. Buffers fabric
//                bytes and presents complete packets on a ready/read port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_out_queue #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [7:0]    port_out,
    output logic          port_ready,
    input  logic          port_read,
    output logic [AW:0]   pkt_count,
    output logic          err_oversize
);

    typedef enum logic [0:0] {
        IN_ACCEPT  = 1'b0,
        IN_DISCARD = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SEND = 2'd1,
        RD_GAP  = 2'd2
    } rd_state_t;

    localparam logic [AW:0] c_ONE = {{AW{1'b0}}, 1'b1};

    // Each entry is {last, data}
    logic [8:0]  r_mem [DEPTH];

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_wr_start;
    logic [AW:0] r_pkt_count;
    logic        r_mid;
    logic        r_pkt_avail;
    logic        r_err;

    in_state_t   r_in_state;
    in_state_t   w_in_next;
    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;

    logic        w_full;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_store;
    logic        w_drop_start;
    logic [8:0]  w_head;
    logic        w_pop;
    logic        w_pop_last;
    logic        w_pkt_inc;

    assign w_full       = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                          (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_in_ready   = (r_in_state == IN_DISCARD) || !w_full;
    assign w_accept     = in_valid && w_in_ready;
    assign w_store      = w_accept && (r_in_state == IN_ACCEPT);
    // A full queue with no complete packet means the partial packet alone
    // fills every slot and can never be forwarded.
    assign w_drop_start = (r_in_state == IN_ACCEPT) && w_full &&
                          (r_pkt_count == '0) && r_mid;
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop        = (r_rd_state == RD_SEND) && port_read;
    assign w_pop_last   = w_pop && w_head[8];
    assign w_pkt_inc    = w_store && in_last;

    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            IN_ACCEPT:  if (w_drop_start) w_in_next = IN_DISCARD;
            IN_DISCARD: if (w_accept && in_last) w_in_next = IN_ACCEPT;
            default:    w_in_next = IN_ACCEPT;
        endcase
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (r_pkt_avail) w_rd_next = RD_SEND;
            RD_SEND: if (w_pop_last) w_rd_next = RD_GAP;
            RD_GAP:  w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_state  <= IN_ACCEPT;
            r_rd_state  <= RD_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_start  <= '0;
            r_pkt_count <= '0;
            r_mid       <= 1'b0;
            r_pkt_avail <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_state <= w_in_next;
            r_rd_state <= w_rd_next;
            r_err      <= w_drop_start;

            if (w_drop_start) begin
                r_wr_ptr <= r_wr_start;
                r_mid    <= 1'b0;
            end else if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
                r_mid    <= !in_last;
            end

            if (w_store && !r_mid) begin
                r_wr_start <= r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end

            case ({w_pkt_inc, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + c_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - c_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase

            // One extra stage so a packet is offered two edges after its last byte
            r_pkt_avail <= (r_pkt_count != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    assign in_ready     = w_in_ready;
    assign port_ready   = (r_rd_state == RD_SEND);
    assign port_out     = (r_rd_state == RD_SEND) ? w_head[7:0] : 8'h00;
    assign pkt_count    = r_pkt_count;
    assign err_oversize = r_err;

endmodule

`default_nettype wire

// File: tb/tb_switch_out_queue.sv
// ============================================================================
//  Module      : tb_switch_out_queue
//  Description : Scoreboard bench for switch_out_queue with a packet-level
//                reference model (packets longer than DEPTH are dropped).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_switch_out_queue;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic [7:0]    port_out;
    logic          port_ready;
    logic          port_read;
    logic [AW:0]   pkt_count;
    logic          err_oversize;

    int            n_cmp;
    int            n_fail;
    int            cyc;
    int            rd_mode;      // 0 hold low, 1 always read, 2 random
    int            exp_err;
    int            seen_err;
    int            gap_left;
    int            stalls_acc;
    logic [8:0]    exp_q[$];
    int            pop_cyc[$];

    switch_out_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .port_out     (port_out),
        .port_ready   (port_ready),
        .port_read    (port_read),
        .pkt_count    (pkt_count),
        .err_oversize (err_oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Consumer: drives port_read just after each rising edge
    initial begin
        port_read = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       port_read = 1'b0;
                1:       port_read = 1'b1;
                default: port_read = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected bytes whenever the DUT hands one over
    initial begin
        logic [8:0] e;
        gap_left = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gap_left = 0;
            end else begin
                if (err_oversize) seen_err++;
                if (gap_left > 0) begin
                    check("gap_port_ready", int'(port_ready), 0);
                    gap_left--;
                end
                if (!port_ready) check("idle_port_out", int'(port_out), 0);
                if (port_ready && port_read) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h, required none (cycle %0d)", port_out, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("port_out", int'(port_out), int'(e[7:0]));
                        pop_cyc.push_back(cyc);
                        if (e[8]) gap_left = 2;
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 5000) begin
                n_fail++;
                $display("FAIL in_ready_timeout: got in_ready=0, required 1 within 5000 cycles");
                $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        stalls_acc += n;
    endtask

    // Model: a packet is delivered intact iff it fits in DEPTH bytes
    task automatic send_pkt(input int len, input logic [7:0] first, input bit rnd, input bit gaps);
        logic [7:0] b[$];
        for (int i = 0; i < len; i++) b.push_back(rnd ? 8'($urandom) : 8'(first + i));
        if (len > DEPTH) exp_err++;
        else for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, b[i]});
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            push_byte(b[i], i == len - 1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        n_cmp = 0; n_fail = 0; cyc = 0; rd_mode = 0;
        exp_err = 0; seen_err = 0; stalls_acc = 0;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_port_ready", int'(port_ready), 0);
        check("rst_port_out", int'(port_out), 0);
        check("rst_pkt_count", int'(pkt_count), 0);
        check("rst_err", int'(err_oversize), 0);
        reset = 1'b0;

        // T1: reset with one complete packet and 3 partial bytes stored
        push_byte(8'h55, 1'b0);
        push_byte(8'h56, 1'b1);
        push_byte(8'h01, 1'b0);
        push_byte(8'h02, 1'b0);
        push_byte(8'h03, 1'b0);
        @(posedge clk); #1;
        check("t1_ready_before", int'(port_ready), 1);
        check("t1_out_before", int'(port_out), 8'h55);
        check("t1_count_before", int'(pkt_count), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t1_port_ready", int'(port_ready), 0);
        check("t1_pkt_count", int'(pkt_count), 0);
        check("t1_in_ready", int'(in_ready), 1);
        check("t1_port_out", int'(port_out), 0);
        repeat (3) @(posedge clk); #1;
        check("t1_still_empty", int'(port_ready), 0);

        // T2: latency and consecutive bytes
        rd_mode = 1;
        @(posedge clk); #1;
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'(8'hA1 + i)});
        push_byte(8'hA1, 1'b0);
        push_byte(8'hA2, 1'b0);
        push_byte(8'hA3, 1'b0);
        push_byte(8'hA4, 1'b1);
        check("t2_ready_e0", int'(port_ready), 0);
        @(posedge clk); #1;
        check("t2_ready_e1", int'(port_ready), 0);
        @(posedge clk); #1;
        check("t2_ready_e2", int'(port_ready), 1);
        check("t2_first_byte", int'(port_out), 8'hA1);
        wait_drain();
        check("t2_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("t2_consecutive", pop_cyc[3] - pop_cyc[0], 3);

        // T3: store-and-forward
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, 8'(8'hB1 + i)});
        push_byte(8'hB1, 1'b0);
        push_byte(8'hB2, 1'b0);
        push_byte(8'hB3, 1'b0);
        hi = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (port_ready) hi++;
        end
        check("t3_no_early_ready", hi, 0);
        push_byte(8'hB4, 1'b1);
        check("t3_pkt_count", int'(pkt_count), 1);
        wait_drain();

        // T4: back-to-back single-byte packets
        pop_cyc.delete();
        exp_q.push_back({1'b1, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        wait_drain();
        check("t4_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) check("t4_spacing", pop_cyc[1] - pop_cyc[0], 3);

        // T5: wrap, then fill to capacity without reading
        stalls_acc = 0;
        send_pkt(40, 8'h40, 1'b0, 1'b0);
        wait_drain();
        send_pkt(60, 8'h80, 1'b0, 1'b0);
        check("t5_no_stall", stalls_acc, 0);
        wait_drain();
        rd_mode = 0;
        repeat (2) @(posedge clk); #1;
        for (int p = 0; p < 16; p++) send_pkt(4, 8'(p * 16), 1'b0, 1'b0);
        check("t5_full_in_ready", int'(in_ready), 0);
        check("t5_full_count", int'(pkt_count), 16);
        rd_mode = 1;
        wait_drain();

        // T6: oversize packet dropped, next packet intact
        send_pkt(70, 8'hC0, 1'b0, 1'b0);
        check("t6_pkt_count", int'(pkt_count), 0);
        repeat (3) @(posedge clk); #1;
        check("t6_err_pulses", seen_err, exp_err);
        check("t6_empty", int'(port_ready), 0);
        send_pkt(5, 8'hE0, 1'b0, 1'b0);
        wait_drain();

        // Random traffic with random consumer
        rd_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 90) : $urandom_range(1, 20);
            send_pkt(len, 8'h00, 1'b1, 1'b1);
        end
        rd_mode = 1;
        wait_drain();
        check("rand_err_pulses", seen_err, exp_err);
        check("rand_pkt_count", int'(pkt_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: got no finish by 800000, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $fatal(1);
    end

endmodule

`default_nettype wire
